lmi_region_decode: RTL and testbench
====================================

// Module: lmi_region_decode
// PURPOSE
//   Programmable multi-region address decoder for the LMI DRAM path: N software-configured
//   [BASE,TOP] windows replace the fixed single-window compare. Accepts one address per cycle
//   over valid/ready, returns a registered hit/region/miss result one cycle later. Latches the
//   first missing address for error reporting. Sits between the LMI request mux and DRAM ctrl.
// PARAMETERS
//   NUM_REGIONS  4   number of address windows (1..16)
//   IDX_W        2   width of region index, = clog2(NUM_REGIONS), min 1
//   ADDR_W       32  request address width
//   GRAN_LO      4   lsb of compared address; window granule = 2**GRAN_LO bytes
// PORTS
//   CLK          in   1                    clock, all state on rising edge
//   RST_N        in   1                    reset, synchronous, active-low
//   CFG_WE       in   1                    config write strobe
//   CFG_IDX      in   IDX_W                region written
//   CFG_SEL      in   2                    0=BASE 1=TOP 2=ENABLE(bit0 of WDATA) 3=reserved(ignored)
//   CFG_WDATA    in   ADDR_W-GRAN_LO       base/top value at granule resolution
//   REQ_VALID    in   1                    request address valid
//   REQ_READY    out  1                    decoder can accept
//   REQ_ADDR     in   ADDR_W               byte address to decode
//   RSP_VALID    out  1                    result valid
//   RSP_READY    in   1                    consumer takes result
//   RSP_HIT      out  1                    address in an enabled window
//   RSP_REGION   out  IDX_W                winning region (0 when miss)
//   ERR_VALID    out  1                    sticky: a miss has been captured
//   ERR_ADDR     out  ADDR_W               address of first captured miss
//   ERR_CLR      in   1                    clears ERR_VALID/ERR_ADDR
// BEHAVIOUR
//   Reset (RST_N=0 at edge): all BASE=0, TOP=0, ENABLE=0; RSP_VALID=0, RSP_HIT=0,
//     RSP_REGION=0, ERR_VALID=0, ERR_ADDR=0. REQ_READY=1 in first cycle after reset.
//     Reset mid-transaction discards any held result; no response for it is produced.
//   Match: A=REQ_ADDR[ADDR_W-1:GRAN_LO]; hit_i = ENABLE_i & (A>=BASE_i) & (A<=TOP_i), unsigned,
//     both bounds inclusive. BASE_i>TOP_i => region i never hits. Overlaps legal: lowest index wins.
//   Handshake: accept when REQ_VALID&REQ_READY. REQ_READY = !RSP_VALID | RSP_READY (combinational,
//     no skid). Result registered: RSP_* valid the cycle after acceptance (latency 1).
//     RSP_* held stable while RSP_VALID&!RSP_READY. Back-to-back: full throughput when RSP_READY=1.
//     RSP_VALID falls after RSP_READY with no new acceptance that cycle.
//   Config: write takes effect at the edge; a request accepted in the same cycle as a CFG write
//     is decoded with the pre-write values. CFG_SEL=3 and CFG_IDX>=NUM_REGIONS are ignored.
//   Error capture: on acceptance of a missing request while ERR_VALID=0, set ERR_VALID=1 and
//     ERR_ADDR=REQ_ADDR (same edge as result register). Further misses don't overwrite.
//     ERR_CLR clears both; ERR_CLR together with a new miss => new miss captured (set wins).
//   Address bits [GRAN_LO-1:0] are not compared; ERR_ADDR keeps the full byte address.
// TESTING
//   1 After reset, REQ_ADDR=0x0000_0000 accepted -> next cycle RSP_VALID=1 RSP_HIT=0,
//     ERR_VALID=1, ERR_ADDR=0x0.
//   2 Region1 BASE=0x100 TOP=0x1FF EN=1; addr 0x1000,0x1FF0,0x1FFF -> hit region1;
//     0x0FF0,0x2000 -> miss.
//   3 Region0 [0x100..0x3FF], region2 [0x200..0x2FF] both enabled; addr 0x2500 -> RSP_REGION=0;
//     disable region0 -> RSP_REGION=2.
//   4 RSP_READY=0 for 3 cycles with REQ_VALID=1: REQ_READY=0, RSP_* stable; RSP_READY=1 ->
//     held result consumed, queued request accepted same cycle, its result next cycle.
//   5 CFG write EN=0 on region1 same cycle as request to 0x1000: that result hits region1;
//     next request to 0x1000 misses.
//   6 Misses 0x4000 then 0x5000 -> ERR_ADDR=0x4000; ERR_CLR with miss 0x6000 same cycle ->
//     ERR_VALID=1 ERR_ADDR=0x6000; RST_N=0 with RSP_VALID=1 -> all outputs zero next cycle.

Source files
------------

// File: rtl/lmi_region_decode.sv
// Programmable multi-window address decoder for the LMI DRAM path.
// Decodes one request per cycle into a registered hit/region result and latches the first miss.
module lmi_region_decode #(
   parameter int NUM_REGIONS = 4,
   parameter int IDX_W       = 2,
   parameter int ADDR_W      = 32,
   parameter int GRAN_LO     = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cfg_we_i,
   input  logic [IDX_W-1:0]          cfg_idx_i,
   input  logic [1:0]                cfg_sel_i,
   input  logic [ADDR_W-GRAN_LO-1:0] cfg_wdata_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [ADDR_W-1:0]         req_addr_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic                      rsp_hit_o,
   output logic [IDX_W-1:0]          rsp_region_o,
   output logic                      err_valid_o,
   output logic [ADDR_W-1:0]         err_addr_o,
   input  logic                      err_clr_i
);

   localparam int GW = ADDR_W - GRAN_LO;

   logic [GW-1:0]          base_q [NUM_REGIONS];
   logic [GW-1:0]          base_d [NUM_REGIONS];
   logic [GW-1:0]          top_q  [NUM_REGIONS];
   logic [GW-1:0]          top_d  [NUM_REGIONS];
   logic [NUM_REGIONS-1:0] en_q, en_d;

   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_hit_q, rsp_hit_d;
   logic [IDX_W-1:0]  rsp_region_q, rsp_region_d;
   logic              err_valid_q, err_valid_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic              accept;
   logic              dec_hit;
   logic [IDX_W-1:0]  dec_region;
   logic [GW-1:0]     gran_addr;

   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = req_valid_i && req_ready_o;
   assign gran_addr   = req_addr_i[ADDR_W-1:GRAN_LO];

   // Scanning from the top index down lets the lowest overlapping window win.
   always_comb begin
      dec_hit    = 1'b0;
      dec_region = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (en_q[i] && (gran_addr >= base_q[i]) && (gran_addr <= top_q[i])) begin
            dec_hit    = 1'b1;
            dec_region = IDX_W'(i);
         end
      end
   end

   always_comb begin
      base_d = base_q;
      top_d  = top_q;
      en_d   = en_q;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
            case (cfg_sel_i)
               2'd0:    base_d[i] = cfg_wdata_i;
               2'd1:    top_d[i]  = cfg_wdata_i;
               2'd2:    en_d[i]   = cfg_wdata_i[0];
               default: ;
            endcase
         end
      end
   end

   // A held result stays untouched until the consumer takes it.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_hit_d    = rsp_hit_q;
      rsp_region_d = rsp_region_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_hit_d    = dec_hit;
         rsp_region_d = dec_region;
      end else if (rsp_ready_i) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // A clear in the same cycle as a new miss still captures that miss.
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      if (err_clr_i) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
      end
      if (accept && !dec_hit && (!err_valid_q || err_clr_i)) begin
         err_valid_d = 1'b1;
         err_addr_d  = req_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            base_q[i] <= '0;
            top_q[i]  <= '0;
         end
         en_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_hit_q    <= 1'b0;
         rsp_region_q <= '0;
         err_valid_q  <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            base_q[i] <= base_d[i];
            top_q[i]  <= top_d[i];
         end
         en_q         <= en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_hit_q    <= rsp_hit_d;
         rsp_region_q <= rsp_region_d;
         err_valid_q  <= err_valid_d;
         err_addr_q   <= err_addr_d;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_hit_o    = rsp_hit_q;
   assign rsp_region_o = rsp_region_q;
   assign err_valid_o  = err_valid_q;
   assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_lmi_region_decode.sv
// Directed bench for lmi_region_decode: table-driven window decode plus
// hand-written sequences for backpressure, same-cycle config, error capture and reset.
module tb_lmi_region_decode;

   localparam int NUM_REGIONS = 4;
   localparam int IDX_W       = 2;
   localparam int ADDR_W      = 32;
   localparam int GRAN_LO     = 4;
   localparam int GW          = ADDR_W - GRAN_LO;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              cfg_we_i;
   logic [IDX_W-1:0]  cfg_idx_i;
   logic [1:0]        cfg_sel_i;
   logic [GW-1:0]     cfg_wdata_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [ADDR_W-1:0] req_addr_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic              rsp_hit_o;
   logic [IDX_W-1:0]  rsp_region_o;
   logic              err_valid_o;
   logic [ADDR_W-1:0] err_addr_o;
   logic              err_clr_i;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  enMask;
      logic [31:0] addr;
      logic        expHit;
      logic [1:0]  expRegion;
   } vec_t;

   vec_t vecs[$];

   lmi_region_decode #(
      .NUM_REGIONS(NUM_REGIONS), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .GRAN_LO(GRAN_LO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_sel_i(cfg_sel_i), .cfg_wdata_i(cfg_wdata_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
      .rsp_region_o(rsp_region_o), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
      .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cfgWrite(input int idx, input logic [1:0] sel, input logic [GW-1:0] data);
      cfg_we_i    = 1'b1;
      cfg_idx_i   = IDX_W'(idx);
      cfg_sel_i   = sel;
      cfg_wdata_i = data;
      tick();
      cfg_we_i    = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] addr);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic setEnables(input logic [3:0] mask);
      for (int r = 0; r < NUM_REGIONS; r++) cfgWrite(r, 2'd2, GW'(mask[r]));
   endtask

   initial begin
      rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_sel_i = '0; cfg_wdata_i = '0;
      req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b1; err_clr_i = 1'b0;

      // Windows: r0 [0x100..0x3FF], r1 [0x100..0x1FF], r2 [0x200..0x2FF], r3 inverted.
      vecs.push_back('{4'b0010, 32'h0000_1000, 1'b1, 2'd1});
      vecs.push_back('{4'b0010, 32'h0000_1FF0, 1'b1, 2'd1});
      vecs.push_back('{4'b0010, 32'h0000_1FFF, 1'b1, 2'd1});
      vecs.push_back('{4'b0010, 32'h0000_0FF0, 1'b0, 2'd0});
      vecs.push_back('{4'b0010, 32'h0000_2000, 1'b0, 2'd0});
      vecs.push_back('{4'b0101, 32'h0000_2500, 1'b1, 2'd0});
      vecs.push_back('{4'b0100, 32'h0000_2500, 1'b1, 2'd2});
      vecs.push_back('{4'b0100, 32'h0000_2FFF, 1'b1, 2'd2});
      vecs.push_back('{4'b0100, 32'h0000_3000, 1'b0, 2'd0});
      vecs.push_back('{4'b0111, 32'h0000_1500, 1'b1, 2'd0});
      vecs.push_back('{4'b0110, 32'h0000_1500, 1'b1, 2'd1});
      vecs.push_back('{4'b1000, 32'h0000_4F00, 1'b0, 2'd0});
      vecs.push_back('{4'b1000, 32'h0000_5000, 1'b0, 2'd0});
      vecs.push_back('{4'b0001, 32'h0000_3FFF, 1'b1, 2'd0});
      vecs.push_back('{4'b0001, 32'h0000_4000, 1'b0, 2'd0});
      vecs.push_back('{4'b0001, 32'h0000_0FFF, 1'b0, 2'd0});

      tick(); tick();
      rst_ni = 1'b1;
      checkOutput("reset_rsp_valid", rsp_valid_o, 0);
      checkOutput("reset_rsp_hit", rsp_hit_o, 0);
      checkOutput("reset_rsp_region", rsp_region_o, 0);
      checkOutput("reset_err_valid", err_valid_o, 0);
      checkOutput("reset_err_addr", err_addr_o, 0);
      checkOutput("reset_req_ready", req_ready_o, 1);

      // Nothing is enabled after reset, so address 0 misses and is captured.
      applyStimulus(32'h0);
      checkOutput("t1_rsp_valid", rsp_valid_o, 1);
      checkOutput("t1_rsp_hit", rsp_hit_o, 0);
      checkOutput("t1_err_valid", err_valid_o, 1);
      checkOutput("t1_err_addr", err_addr_o, 0);
      tick();
      checkOutput("t1_rsp_drop", rsp_valid_o, 0);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      checkOutput("t1_err_clr", err_valid_o, 0);

      cfgWrite(0, 2'd0, GW'(28'h100)); cfgWrite(0, 2'd1, GW'(28'h3FF));
      cfgWrite(1, 2'd0, GW'(28'h100)); cfgWrite(1, 2'd1, GW'(28'h1FF));
      cfgWrite(2, 2'd0, GW'(28'h200)); cfgWrite(2, 2'd1, GW'(28'h2FF));
      cfgWrite(3, 2'd0, GW'(28'h500)); cfgWrite(3, 2'd1, GW'(28'h4FF));
      // Reserved select must leave region 1's top untouched.
      cfgWrite(1, 2'd3, GW'(28'h0));

      foreach (vecs[k]) begin
         setEnables(vecs[k].enMask);
         applyStimulus(vecs[k].addr);
         checkOutput($sformatf("vec%0d_valid", k), rsp_valid_o, 1);
         checkOutput($sformatf("vec%0d_hit", k), rsp_hit_o, vecs[k].expHit);
         checkOutput($sformatf("vec%0d_region", k), rsp_region_o, vecs[k].expRegion);
      end

      // Backpressure: hold a hit result while a miss request waits.
      setEnables(4'b0010);
      tick();
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1; req_addr_i = 32'h0000_1000;
      tick();
      req_addr_i = 32'h0000_2000;
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("t4_req_ready_c%0d", c), req_ready_o, 0);
         checkOutput($sformatf("t4_rsp_valid_c%0d", c), rsp_valid_o, 1);
         checkOutput($sformatf("t4_rsp_hit_c%0d", c), rsp_hit_o, 1);
         checkOutput($sformatf("t4_rsp_region_c%0d", c), rsp_region_o, 1);
         tick();
      end
      rsp_ready_i = 1'b1;
      #1;
      checkOutput("t4_req_ready_release", req_ready_o, 1);
      tick();
      req_valid_i = 1'b0;
      checkOutput("t4_queued_valid", rsp_valid_o, 1);
      checkOutput("t4_queued_hit", rsp_hit_o, 0);
      checkOutput("t4_queued_region", rsp_region_o, 0);
      tick();
      checkOutput("t4_drain", rsp_valid_o, 0);

      // Config write in the same cycle as a request uses the old enable.
      cfg_we_i = 1'b1; cfg_idx_i = 2'd1; cfg_sel_i = 2'd2; cfg_wdata_i = '0;
      req_valid_i = 1'b1; req_addr_i = 32'h0000_1000;
      tick();
      cfg_we_i = 1'b0;
      checkOutput("t5_same_cycle_hit", rsp_hit_o, 1);
      checkOutput("t5_same_cycle_region", rsp_region_o, 1);
      tick();
      req_valid_i = 1'b0;
      checkOutput("t5_after_hit", rsp_hit_o, 0);

      // Error capture ordering.
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      checkOutput("t6_cleared", err_valid_o, 0);
      applyStimulus(32'h0000_4000);
      applyStimulus(32'h0000_5000);
      checkOutput("t6_first_valid", err_valid_o, 1);
      checkOutput("t6_first_addr", err_addr_o, 32'h0000_4000);
      err_clr_i = 1'b1;
      applyStimulus(32'h0000_6000);
      err_clr_i = 1'b0;
      checkOutput("t6_clr_set_valid", err_valid_o, 1);
      checkOutput("t6_clr_set_addr", err_addr_o, 32'h0000_6000);

      // Reset while a hit result is held discards it and all config.
      cfgWrite(2, 2'd2, GW'(1));
      rsp_ready_i = 1'b0;
      applyStimulus(32'h0000_2500);
      checkOutput("t6_pre_reset_hit", rsp_hit_o, 1);
      checkOutput("t6_pre_reset_region", rsp_region_o, 2);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      rsp_ready_i = 1'b1;
      checkOutput("t6_rst_rsp_valid", rsp_valid_o, 0);
      checkOutput("t6_rst_rsp_hit", rsp_hit_o, 0);
      checkOutput("t6_rst_rsp_region", rsp_region_o, 0);
      checkOutput("t6_rst_err_valid", err_valid_o, 0);
      checkOutput("t6_rst_err_addr", err_addr_o, 0);
      checkOutput("t6_rst_req_ready", req_ready_o, 1);
      applyStimulus(32'h0000_2500);
      checkOutput("t6_post_rst_hit", rsp_hit_o, 0);
      checkOutput("t6_post_rst_err_addr", err_addr_o, 32'h0000_2500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
